// File: rtl/fdtd_mem_seq.sv
// Memory-side sequencer for the FDTD field buffer: streams Hy/Ez/source words between
// data memory and the buffer. Optional transfer checksum output: define FDTD_MEMSEQ_CHKSUM_EN.
module fdtd_mem_seq #(
   parameter int FDTD_DATA_WIDTH   = 32,
   parameter int BUFFER_ADDR_WIDTH = 6,
   parameter int DM_ADDR_WIDTH     = 16
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic                         cmd_valid_i,
   output logic                         cmd_ready_o,
   input  logic [2:0]                   cmd_op_i,
   input  logic [DM_ADDR_WIDTH-1:0]     cmd_base_i,
   input  logic [BUFFER_ADDR_WIDTH:0]   cmd_len_i,
   output logic                         done_o,
   output logic                         err_o,
`ifdef FDTD_MEMSEQ_CHKSUM_EN
   output logic [FDTD_DATA_WIDTH-1:0]   chksum_o,
`endif
   output logic                         dm_req_o,
   output logic                         dm_we_o,
   output logic [DM_ADDR_WIDTH-1:0]     dm_addr_o,
   output logic [FDTD_DATA_WIDTH-1:0]   dm_wdata_o,
   input  logic                         dm_gnt_i,
   input  logic                         dm_rvalid_i,
   input  logic [FDTD_DATA_WIDTH-1:0]   dm_rdata_i,
   output logic                         buffer_Hy_start_o,
   output logic                         buffer_Ez_start_o,
   output logic                         buffer_src_start_o,
   output logic                         buffer_Hy_end_o,
   output logic                         buffer_Ez_end_o,
   output logic                         buffer_src_end_o,
   output logic                         wrtvalid_Hy_old_o,
   output logic                         wrtvalid_Ez_old_o,
   output logic [FDTD_DATA_WIDTH-1:0]   Hy_old_o,
   output logic [FDTD_DATA_WIDTH-1:0]   Ez_old_o,
   output logic                         mem_rd_Hy_en_o,
   output logic                         mem_rd_Ez_en_o,
   output logic                         mem_rd_end_o,
   output logic                         wrtvalid_sgl_o,
   input  logic [FDTD_DATA_WIDTH-1:0]   Hy_n_i,
   input  logic [FDTD_DATA_WIDTH-1:0]   Ez_n_i
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_LD_START = 4'd1;
   localparam logic [3:0] S_LD_GAP   = 4'd2;
   localparam logic [3:0] S_LD_RUN   = 4'd3;
   localparam logic [3:0] S_LD_END   = 4'd4;
   localparam logic [3:0] S_ST_EN    = 4'd5;
   localparam logic [3:0] S_ST_GAP   = 4'd6;
   localparam logic [3:0] S_ST_RUN   = 4'd7;
   localparam logic [3:0] S_ST_END   = 4'd8;

   localparam logic [2:0] OP_LD_HY  = 3'd0;
   localparam logic [2:0] OP_LD_EZ  = 3'd1;
   localparam logic [2:0] OP_LD_SRC = 3'd2;
   localparam logic [2:0] OP_ST_HY  = 3'd3;
   localparam logic [2:0] OP_ST_EZ  = 3'd4;

   localparam logic [BUFFER_ADDR_WIDTH:0] LP_MAX_LEN  = {1'b1, {BUFFER_ADDR_WIDTH{1'b0}}};
   localparam logic [BUFFER_ADDR_WIDTH:0] LP_CNT_ZERO = '0;
   localparam logic [BUFFER_ADDR_WIDTH:0] LP_CNT_ONE  = {{BUFFER_ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [DM_ADDR_WIDTH-1:0]   LP_ADDR_ONE = {{(DM_ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [3:0]                   r_state;
   logic [2:0]                   r_op;
   logic [BUFFER_ADDR_WIDTH:0]   r_len;
   logic [BUFFER_ADDR_WIDTH:0]   r_issued;
   logic [BUFFER_ADDR_WIDTH:0]   r_xfer;
   logic [DM_ADDR_WIDTH-1:0]     r_addr;
   logic                         r_gap;
   logic                         r_wait_flag;
   logic                         r_err;
   logic                         r_ld_done;
   logic                         r_wrtvalid_hy;
   logic                         r_wrtvalid_ez;
   logic [FDTD_DATA_WIDTH-1:0]   r_hy_old;
   logic [FDTD_DATA_WIDTH-1:0]   r_ez_old;
   logic                         r_inflight;
   logic [1:0]                   r_qcnt;
   logic [FDTD_DATA_WIDTH-1:0]   r_q0;
   logic [FDTD_DATA_WIDTH-1:0]   r_q1;

   logic                         w_idle;
   logic                         w_len_ok;
   logic                         w_op_ok;
   logic                         w_cmd_is_store;
   logic                         w_legal;
   logic                         w_accept;
   logic                         w_reject;
   logic                         w_ld_req;
   logic                         w_st_req;
   logic                         w_req;
   logic                         w_gnt;
   logic                         w_sgl;
   logic                         w_push;
   logic                         w_pop;
   logic                         w_ld_rvalid;
   logic                         w_last_wr;
   logic                         w_op_hy;
   logic [FDTD_DATA_WIDTH-1:0]   w_buf_data;
   logic [1:0]                   w_occupancy;

   // Command screening: stores are only legal once an Ez/src load has primed the buffer.
   assign w_idle         = (r_state == S_IDLE);
   assign w_len_ok       = (cmd_len_i != LP_CNT_ZERO) && (cmd_len_i <= LP_MAX_LEN);
   assign w_op_ok        = (cmd_op_i <= OP_ST_EZ);
   assign w_cmd_is_store = (cmd_op_i == OP_ST_HY) || (cmd_op_i == OP_ST_EZ);
   assign w_legal        = w_len_ok && w_op_ok && (!w_cmd_is_store || r_wait_flag);
   assign w_accept       = w_idle && cmd_valid_i && w_legal;
   assign w_reject       = w_idle && cmd_valid_i && !w_legal;

   assign w_op_hy     = (r_op == OP_LD_HY) || (r_op == OP_ST_HY);
   assign w_ld_req    = (r_state == S_LD_RUN) && (r_issued < r_len);
   assign w_st_req    = (r_state == S_ST_RUN) && (r_qcnt != 2'd0);
   assign w_req       = w_ld_req || w_st_req;
   assign w_gnt       = w_req && dm_gnt_i;
   assign w_ld_rvalid = (r_state == S_LD_RUN) && dm_rvalid_i;

   // A strobe is only issued when the word it produces is guaranteed a queue slot.
   assign w_occupancy = {1'b0, r_inflight} + r_qcnt;
   assign w_sgl       = (r_state == S_ST_RUN) && (r_issued < r_len) && (w_occupancy < 2'd2);
   assign w_push      = r_inflight;
   assign w_pop       = w_st_req && dm_gnt_i;
   assign w_last_wr   = w_pop && (r_xfer == (r_len - LP_CNT_ONE));
   assign w_buf_data  = w_op_hy ? Hy_n_i : Ez_n_i;

   // Sequencing FSM and the wait flag that mirrors the buffer's store permission.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= S_IDLE;
         r_gap       <= 1'b0;
         r_wait_flag <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= w_cmd_is_store ? S_ST_EN : S_LD_START;
               end
            end
            S_LD_START: begin
               r_gap   <= (r_op != OP_LD_SRC);
               r_state <= S_LD_GAP;
            end
            S_LD_GAP: begin
               if (r_gap) begin
                  r_gap <= 1'b0;
               end else begin
                  r_state <= S_LD_RUN;
               end
            end
            S_LD_RUN: begin
               if (r_xfer == r_len) begin
                  r_state <= S_LD_END;
               end
            end
            S_LD_END: begin
               r_wait_flag <= (r_op != OP_LD_HY);
               r_state     <= S_IDLE;
            end
            S_ST_EN: begin
               r_state <= S_ST_GAP;
            end
            S_ST_GAP: begin
               r_state <= S_ST_RUN;
            end
            S_ST_RUN: begin
               if (w_last_wr) begin
                  r_state <= S_ST_END;
               end
            end
            S_ST_END: begin
               r_wait_flag <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Command latch, memory address and the issue/transfer counters.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_op     <= 3'd0;
         r_len    <= LP_CNT_ZERO;
         r_addr   <= '0;
         r_issued <= LP_CNT_ZERO;
         r_xfer   <= LP_CNT_ZERO;
      end else if (w_accept) begin
         r_op     <= cmd_op_i;
         r_len    <= cmd_len_i;
         r_addr   <= cmd_base_i;
         r_issued <= LP_CNT_ZERO;
         r_xfer   <= LP_CNT_ZERO;
      end else begin
         if (w_gnt) begin
            r_addr <= r_addr + LP_ADDR_ONE;
         end
         if ((w_ld_req && dm_gnt_i) || w_sgl) begin
            r_issued <= r_issued + LP_CNT_ONE;
         end
         if (w_ld_rvalid || w_pop) begin
            r_xfer <= r_xfer + LP_CNT_ONE;
         end
      end
   end

   // Load return path: each read word is registered and strobed into the buffer.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_wrtvalid_hy <= 1'b0;
         r_wrtvalid_ez <= 1'b0;
         r_hy_old      <= '0;
         r_ez_old      <= '0;
      end else begin
         r_wrtvalid_hy <= w_ld_rvalid && (r_op == OP_LD_HY);
         r_wrtvalid_ez <= w_ld_rvalid && (r_op != OP_LD_HY);
         if (w_ld_rvalid && (r_op == OP_LD_HY)) begin
            r_hy_old <= dm_rdata_i;
         end else if (w_ld_rvalid) begin
            r_ez_old <= dm_rdata_i;
         end
      end
   end

   // Two-entry holding queue between buffer reads and memory writes.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_inflight <= 1'b0;
         r_qcnt     <= 2'd0;
         r_q0       <= '0;
         r_q1       <= '0;
      end else begin
         r_inflight <= w_sgl;
         if (w_push && w_pop) begin
            if (r_qcnt == 2'd1) begin
               r_q0 <= w_buf_data;
            end else begin
               r_q0 <= r_q1;
               r_q1 <= w_buf_data;
            end
         end else if (w_push) begin
            if (r_qcnt == 2'd0) begin
               r_q0 <= w_buf_data;
            end else begin
               r_q1 <= w_buf_data;
            end
            r_qcnt <= r_qcnt + 2'd1;
         end else if (w_pop) begin
            r_q0   <= r_q1;
            r_qcnt <= r_qcnt - 2'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_err     <= 1'b0;
         r_ld_done <= 1'b0;
      end else begin
         r_err     <= w_reject;
         r_ld_done <= (r_state == S_LD_END);
      end
   end

`ifdef FDTD_MEMSEQ_CHKSUM_EN
   logic [FDTD_DATA_WIDTH-1:0] r_chksum;

   // Running sum of every word moved by the current command.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_chksum <= '0;
      end else if (w_accept) begin
         r_chksum <= '0;
      end else if (w_ld_rvalid) begin
         r_chksum <= r_chksum + dm_rdata_i;
      end else if (w_pop) begin
         r_chksum <= r_chksum + r_q0;
      end
   end

   assign chksum_o = r_chksum;
`endif

   assign cmd_ready_o = w_idle;
   assign done_o      = r_ld_done || (r_state == S_ST_END);
   assign err_o       = r_err;

   assign dm_req_o   = w_req;
   assign dm_we_o    = w_st_req;
   assign dm_addr_o  = r_addr;
   assign dm_wdata_o = w_st_req ? r_q0 : '0;

   assign buffer_Hy_start_o  = (r_state == S_LD_START) && (r_op == OP_LD_HY);
   assign buffer_Ez_start_o  = (r_state == S_LD_START) && (r_op == OP_LD_EZ);
   assign buffer_src_start_o = (r_state == S_LD_START) && (r_op == OP_LD_SRC);
   assign buffer_Hy_end_o    = (r_state == S_LD_END) && (r_op == OP_LD_HY);
   assign buffer_Ez_end_o    = (r_state == S_LD_END) && (r_op == OP_LD_EZ);
   assign buffer_src_end_o   = (r_state == S_LD_END) && (r_op == OP_LD_SRC);

   assign wrtvalid_Hy_old_o = r_wrtvalid_hy;
   assign wrtvalid_Ez_old_o = r_wrtvalid_ez;
   assign Hy_old_o          = r_hy_old;
   assign Ez_old_o          = r_ez_old;

   assign mem_rd_Hy_en_o = (r_state == S_ST_EN) && (r_op == OP_ST_HY);
   assign mem_rd_Ez_en_o = (r_state == S_ST_EN) && (r_op == OP_ST_EZ);
   assign mem_rd_end_o   = (r_state == S_ST_END);
   assign wrtvalid_sgl_o = w_sgl;

endmodule

// File: tb/tb_fdtd_mem_seq.sv
// Directed bench for fdtd_mem_seq: a memory responder and buffer model run inside the
// per-cycle step task; expected values are hand-computed constants.
module tb_fdtd_mem_seq;

   logic        CLK;
   logic        RST_N;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [2:0]  cmd_op_i;
   logic [15:0] cmd_base_i;
   logic [6:0]  cmd_len_i;
   logic        done_o;
   logic        err_o;
`ifdef FDTD_MEMSEQ_CHKSUM_EN
   logic [31:0] chksum_o;
`endif
   logic        dm_req_o;
   logic        dm_we_o;
   logic [15:0] dm_addr_o;
   logic [31:0] dm_wdata_o;
   logic        dm_gnt_i;
   logic        dm_rvalid_i;
   logic [31:0] dm_rdata_i;
   logic        buffer_Hy_start_o, buffer_Ez_start_o, buffer_src_start_o;
   logic        buffer_Hy_end_o, buffer_Ez_end_o, buffer_src_end_o;
   logic        wrtvalid_Hy_old_o, wrtvalid_Ez_old_o;
   logic [31:0] Hy_old_o, Ez_old_o;
   logic        mem_rd_Hy_en_o, mem_rd_Ez_en_o, mem_rd_end_o;
   logic        wrtvalid_sgl_o;
   logic [31:0] Hy_n_i, Ez_n_i;

   fdtd_mem_seq #(
      .FDTD_DATA_WIDTH(32), .BUFFER_ADDR_WIDTH(6), .DM_ADDR_WIDTH(16)
   ) dut (
      .CLK(CLK), .RST_N(RST_N),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
      .cmd_base_i(cmd_base_i), .cmd_len_i(cmd_len_i),
      .done_o(done_o), .err_o(err_o),
`ifdef FDTD_MEMSEQ_CHKSUM_EN
      .chksum_o(chksum_o),
`endif
      .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o),
      .dm_gnt_i(dm_gnt_i), .dm_rvalid_i(dm_rvalid_i), .dm_rdata_i(dm_rdata_i),
      .buffer_Hy_start_o(buffer_Hy_start_o), .buffer_Ez_start_o(buffer_Ez_start_o),
      .buffer_src_start_o(buffer_src_start_o),
      .buffer_Hy_end_o(buffer_Hy_end_o), .buffer_Ez_end_o(buffer_Ez_end_o),
      .buffer_src_end_o(buffer_src_end_o),
      .wrtvalid_Hy_old_o(wrtvalid_Hy_old_o), .wrtvalid_Ez_old_o(wrtvalid_Ez_old_o),
      .Hy_old_o(Hy_old_o), .Ez_old_o(Ez_old_o),
      .mem_rd_Hy_en_o(mem_rd_Hy_en_o), .mem_rd_Ez_en_o(mem_rd_Ez_en_o),
      .mem_rd_end_o(mem_rd_end_o), .wrtvalid_sgl_o(wrtvalid_sgl_o),
      .Hy_n_i(Hy_n_i), .Ez_n_i(Ez_n_i)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int vecCount = 0;
   int missCount = 0;
   int cyc = 0;

   int gntMode = 0;
   int stallFrom = 0;
   logic        pendRead = 1'b0;
   logic [15:0] pendAddr = '0;
   logic        pendStrobe = 1'b0;
   logic [31:0] dataBase = '0;
   int          bufIdx = 0;

   int startCnt, endCnt, hyStrobeCnt, ezStrobeCnt, rdHyEnCnt, rdEzEnCnt, rdEndCnt;
   int doneCnt, errCnt, reqCnt, pulseCnt, sglCnt, maxOut, issueCycle;
   int startCycle, endCycle, firstStrobe, lastStrobe, doneCycle, rdEndCycle, errCycle;
   logic [31:0] loadData[$];
   logic [15:0] wrAddr[$];
   logic [31:0] wrData[$];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      assert (obs === exp) else begin
         missCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clearMonitors();
      startCnt = 0; endCnt = 0; hyStrobeCnt = 0; ezStrobeCnt = 0;
      rdHyEnCnt = 0; rdEzEnCnt = 0; rdEndCnt = 0; doneCnt = 0; errCnt = 0;
      reqCnt = 0; pulseCnt = 0; sglCnt = 0; maxOut = 0; bufIdx = 0;
      startCycle = -1; endCycle = -1; firstStrobe = -1; lastStrobe = -1;
      doneCycle = -1; rdEndCycle = -1; errCycle = -1;
      loadData.delete(); wrAddr.delete(); wrData.delete();
   endtask

   // One clock cycle: observe outputs at the falling edge, then drive memory and buffer inputs.
   task automatic stepCycle();
      logic        nextRvalid;
      logic [15:0] nextAddr;
      int          outNow;
      @(negedge CLK);
      cyc++;
      if (buffer_Hy_start_o || buffer_Ez_start_o || buffer_src_start_o) begin
         startCnt++; startCycle = cyc;
      end
      if (buffer_Hy_end_o || buffer_Ez_end_o || buffer_src_end_o) begin
         endCnt++; endCycle = cyc;
      end
      if (wrtvalid_Hy_old_o) begin
         hyStrobeCnt++; loadData.push_back(Hy_old_o); lastStrobe = cyc;
         if (firstStrobe < 0) firstStrobe = cyc;
      end
      if (wrtvalid_Ez_old_o) begin
         ezStrobeCnt++; loadData.push_back(Ez_old_o); lastStrobe = cyc;
         if (firstStrobe < 0) firstStrobe = cyc;
      end
      if (mem_rd_Hy_en_o) rdHyEnCnt++;
      if (mem_rd_Ez_en_o) rdEzEnCnt++;
      if (mem_rd_end_o) begin rdEndCnt++; rdEndCycle = cyc; end
      if (done_o) begin doneCnt++; doneCycle = cyc; end
      if (err_o) begin errCnt++; errCycle = cyc; end
      if (dm_req_o) reqCnt++;
      pulseCnt += int'(buffer_Hy_start_o) + int'(buffer_Ez_start_o) + int'(buffer_src_start_o)
                + int'(buffer_Hy_end_o) + int'(buffer_Ez_end_o) + int'(buffer_src_end_o)
                + int'(wrtvalid_Hy_old_o) + int'(wrtvalid_Ez_old_o) + int'(mem_rd_Hy_en_o)
                + int'(mem_rd_Ez_en_o) + int'(mem_rd_end_o) + int'(wrtvalid_sgl_o);

      nextRvalid = pendRead;
      nextAddr   = pendAddr;
      case (gntMode)
         1:       dm_gnt_i = ((cyc % 3) != 2);
         2:       dm_gnt_i = !((cyc >= stallFrom) && (cyc < stallFrom + 5));
         default: dm_gnt_i = 1'b1;
      endcase
      pendRead    = dm_req_o && !dm_we_o && dm_gnt_i;
      pendAddr    = dm_addr_o;
      dm_rvalid_i = nextRvalid;
      dm_rdata_i  = nextRvalid ? {16'h0000, nextAddr} : 32'hDEAD_BEEF;

      if (dm_req_o && dm_we_o && dm_gnt_i) begin
         wrAddr.push_back(dm_addr_o);
         wrData.push_back(dm_wdata_o);
      end

      if (pendStrobe) begin
         Hy_n_i = dataBase + 32'(bufIdx);
         Ez_n_i = dataBase + 32'(bufIdx);
         bufIdx++;
      end
      if (wrtvalid_sgl_o) sglCnt++;
      pendStrobe = wrtvalid_sgl_o;
      outNow = sglCnt - wrAddr.size();
      if (outNow > maxOut) maxOut = outNow;
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [15:0] base, input logic [6:0] len);
      clearMonitors();
      cmd_op_i    = op;
      cmd_base_i  = base;
      cmd_len_i   = len;
      cmd_valid_i = 1'b1;
      issueCycle  = cyc;
      stepCycle();
      cmd_valid_i = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int budget);
      for (int i = 0; i < budget && doneCnt == 0; i++) stepCycle();
      checkOutput({tag, "_done"}, doneCnt, 1);
      stepCycle();
      stepCycle();
   endtask

   task automatic checkRejected(input string tag);
      for (int i = 0; i < 4; i++) stepCycle();
      checkOutput({tag, "_err_cnt"}, errCnt, 1);
      checkOutput({tag, "_err_lat"}, errCycle - issueCycle, 1);
      checkOutput({tag, "_quiet"}, reqCnt + pulseCnt + doneCnt, 0);
   endtask

   initial begin
      int bad;
      RST_N = 1'b0;
      cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_base_i = '0; cmd_len_i = '0;
      dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0; dm_rdata_i = '0;
      Hy_n_i = '0; Ez_n_i = '0;
      clearMonitors();
      $display("[TB] start");
      stepCycle(); stepCycle();
      checkOutput("rst_ready", cmd_ready_o, 1);
      checkOutput("rst_req", dm_req_o, 0);
      checkOutput("rst_done_err", {done_o, err_o}, 0);
      checkOutput("rst_hy_old", Hy_old_o, 0);
      checkOutput("rst_pulses", pulseCnt, 0);
      RST_N = 1'b1;
      stepCycle();

      // Stores from reset and malformed commands are rejected.
      applyStimulus(3'd3, 16'h0000, 7'd4);
      checkRejected("st_hy_reset");
      applyStimulus(3'd0, 16'h0000, 7'd0);
      checkRejected("len0");
      applyStimulus(3'd0, 16'h0000, 7'd65);
      checkRejected("len65");
      applyStimulus(3'd6, 16'h0000, 7'd4);
      checkRejected("op6");

      // LD_HY base 0x100 len 4, grant always high.
      gntMode = 0;
      applyStimulus(3'd0, 16'h0100, 7'd4);
      waitDone("ld_hy", 40);
      checkOutput("ld_hy_start", startCnt, 1);
      checkOutput("ld_hy_strobes", hyStrobeCnt, 4);
      checkOutput("ld_hy_first_lat", firstStrobe - startCycle, 5);
      checkOutput("ld_hy_contig", lastStrobe - firstStrobe, 3);
      bad = 0;
      for (int i = 0; i < loadData.size(); i++)
         if (loadData[i] !== 32'h100 + 32'(i)) bad++;
      checkOutput("ld_hy_data", bad, 0);
      checkOutput("ld_hy_end_lat", endCycle - lastStrobe, 1);
      checkOutput("ld_hy_done_lat", doneCycle - endCycle, 1);
`ifdef FDTD_MEMSEQ_CHKSUM_EN
      checkOutput("ld_hy_chksum", chksum_o, 32'h406);
`endif

      // LD_EZ len 64 with the grant low every third cycle.
      gntMode = 1;
      applyStimulus(3'd1, 16'h0300, 7'd64);
      waitDone("ld_ez64", 300);
      checkOutput("ld_ez64_strobes", ezStrobeCnt, 64);
      bad = 0;
      for (int i = 0; i < loadData.size(); i++)
         if (loadData[i] !== 32'h300 + 32'(i)) bad++;
      checkOutput("ld_ez64_order", bad, 0);
      checkOutput("ld_ez64_end_lat", endCycle - lastStrobe, 1);

      // ST_EZ base 0x200 len 3, buffer supplies 0xA0+k.
      gntMode = 0;
      dataBase = 32'hA0;
      applyStimulus(3'd4, 16'h0200, 7'd3);
      waitDone("st_ez", 40);
      checkOutput("st_ez_en", rdEzEnCnt, 1);
      checkOutput("st_ez_nwr", wrAddr.size(), 3);
      for (int i = 0; i < wrAddr.size() && i < 3; i++) begin
         checkOutput($sformatf("st_ez_addr%0d", i), wrAddr[i], 32'h200 + 32'(i));
         checkOutput($sformatf("st_ez_data%0d", i), wrData[i], 32'hA0 + 32'(i));
      end
      checkOutput("st_ez_end_with_done", rdEndCycle - doneCycle, 0);
      checkOutput("st_ez_end_cnt", rdEndCnt, 1);
`ifdef FDTD_MEMSEQ_CHKSUM_EN
      checkOutput("st_ez_chksum", chksum_o, 32'h1E3);
`endif

      // Store cleared the wait flag, so a second store must be refused.
      applyStimulus(3'd4, 16'h0200, 7'd3);
      checkRejected("st_after_st");

      // Re-prime with an Ez load, then ST_HY with a 5-cycle grant stall.
      applyStimulus(3'd1, 16'h0400, 7'd2);
      waitDone("ld_ez2", 40);
      checkOutput("ld_ez2_strobes", ezStrobeCnt, 2);
      gntMode = 2;
      dataBase = 32'h5000;
      applyStimulus(3'd3, 16'h0500, 7'd6);
      stallFrom = cyc + 4;
      waitDone("st_hy_stall", 80);
      checkOutput("st_hy_en", rdHyEnCnt, 1);
      checkOutput("st_hy_strobes", sglCnt, 6);
      checkOutput("st_hy_max_out", maxOut, 2);
      checkOutput("st_hy_nwr", wrAddr.size(), 6);
      bad = 0;
      for (int i = 0; i < wrAddr.size(); i++)
         if (wrAddr[i] !== 16'h500 + 16'(i) || wrData[i] !== 32'h5000 + 32'(i)) bad++;
      checkOutput("st_hy_words", bad, 0);

      // Reset in the middle of an 8-word LD_HY.
      gntMode = 0;
      applyStimulus(3'd0, 16'h0600, 7'd8);
      for (int i = 0; i < 30 && hyStrobeCnt < 2; i++) stepCycle();
      checkOutput("mid_rst_reached", hyStrobeCnt, 2);
      RST_N = 1'b0;
      pendRead = 1'b0;
      #1;
      checkOutput("mid_rst_ready", cmd_ready_o, 1);
      checkOutput("mid_rst_req", dm_req_o, 0);
      checkOutput("mid_rst_strobe", {wrtvalid_Hy_old_o, Hy_old_o}, 0);
      stepCycle(); stepCycle();
      RST_N = 1'b1;
      stepCycle(); stepCycle();
      checkOutput("mid_rst_no_end", endCnt + doneCnt, 0);

      // LD_SRC len 2 after the abort completes normally.
      applyStimulus(3'd2, 16'h0700, 7'd2);
      waitDone("ld_src", 40);
      checkOutput("ld_src_start", startCnt, 1);
      checkOutput("ld_src_strobes", ezStrobeCnt, 2);
      checkOutput("ld_src_first_lat", firstStrobe - startCycle, 4);
      checkOutput("ld_src_data", {loadData.size() == 2 ? loadData[1] : 32'h0}, 32'h701);
      checkOutput("ld_src_end", endCnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/fdtd_mem_seq.md
Name: fdtd_mem_seq

Overview:
- Memory-side sequencer for the FDTD field buffer.
- Load commands stream previous-timestep Hy/Ez/source words from data memory into the buffer, driving the buffer's start, write-valid, data and end handshake.
- Store commands drain current-timestep Hy/Ez words from the buffer back into data memory, driving the buffer's read-enable, single-word strobe and end handshake.
- Sits between the FDTD control FSM and the shared data-memory port.

Parameters:
- FDTD_DATA_WIDTH, 32, field word width.
- BUFFER_ADDR_WIDTH, 6, buffer depth is 2^BUFFER_ADDR_WIDTH words.
- DM_ADDR_WIDTH, 16, data-memory word address width.

Ports:
- CLK  in  1  clock
- RST_N  in  1  async active-low reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  high in IDLE; command accepted when valid&ready
- cmd_op_i  in  3  0 LD_HY, 1 LD_EZ, 2 LD_SRC, 3 ST_HY, 4 ST_EZ; 5-7 illegal
- cmd_base_i  in  DM_ADDR_WIDTH  first data-memory address
- cmd_len_i  in  BUFFER_ADDR_WIDTH+1  word count, legal range 1..2^BUFFER_ADDR_WIDTH
- done_o  out  1  one-cycle pulse when a command completes
- err_o  out  1  one-cycle pulse when a command is rejected
- dm_req_o / dm_we_o  out  1 / 1  memory request / write
- dm_addr_o  out  DM_ADDR_WIDTH  memory address
- dm_wdata_o  out  FDTD_DATA_WIDTH  memory write data
- dm_gnt_i  in  1  request accepted this cycle
- dm_rvalid_i / dm_rdata_i  in  1 / FDTD_DATA_WIDTH  read data, exactly 1 cycle after a granted read
- buffer_Hy_start_o, buffer_Ez_start_o, buffer_src_start_o  out  1  load start pulses
- buffer_Hy_end_o, buffer_Ez_end_o, buffer_src_end_o  out  1  load end pulses
- wrtvalid_Hy_old_o, wrtvalid_Ez_old_o  out  1  load word strobes
- Hy_old_o, Ez_old_o  out  FDTD_DATA_WIDTH  load data
- mem_rd_Hy_en_o, mem_rd_Ez_en_o, mem_rd_end_o  out  1  store handshake pulses
- wrtvalid_sgl_o  out  1  store word strobe
- Hy_n_i, Ez_n_i  in  FDTD_DATA_WIDTH  buffer read data, valid 1 cycle after wrtvalid_sgl_o

Behaviour:
- Clock and reset: single clock CLK; RST_N is asynchronous, active-low.
- Reset values: every output is 0 except cmd_ready_o=1; the FSM goes to IDLE; the stored flag is cleared.
- FSM states: IDLE, LD_START, LD_GAP, LD_RUN, LD_END, ST_EN, ST_GAP, ST_RUN, ST_END.
- IDLE, command rejected with err_o pulse the next cycle and no other activity:
  - cmd_len_i = 0 or cmd_len_i > 2^BUFFER_ADDR_WIDTH;
  - illegal op;
  - any store while the wait flag is 0.
- The wait flag is set by completion of LD_EZ or LD_SRC and cleared by completion of LD_HY, ST_HY or ST_EZ. This mirrors the buffer, which accepts stores only after an Ez/src load.
- LD_START: pulse the matching start output for 1 cycle.
- LD_GAP:
  - LD_HY and LD_EZ wait 2 cycles, because the buffer re-registers these starts.
  - LD_SRC waits 1 cycle.
- LD_RUN, request side:
  - Issue reads at cmd_base_i, incrementing; dm_addr_o wraps modulo 2^DM_ADDR_WIDTH.
  - The address advances only on dm_req_o & dm_gnt_i.
  - dm_req_o drops once len reads are granted.
- LD_RUN, return side:
  - Each dm_rvalid_i is registered into Hy_old_o (LD_HY) or Ez_old_o (LD_EZ/LD_SRC), with the matching wrtvalid strobe 1 cycle later.
  - Strobes may be non-contiguous when grants stall.
- LD_END: the matching end pulse appears the cycle after the last strobe, then done_o, then IDLE.
- ST_EN: pulse mem_rd_Hy_en_o or mem_rd_Ez_en_o for 1 cycle.
- ST_GAP: 1 cycle.
- ST_RUN:
  - Assert wrtvalid_sgl_o while total issued < len and (in-flight reads + held words) < 2.
  - Capture Hy_n_i/Ez_n_i 1 cycle after each strobe into a 2-entry holding queue.
  - Issue writes from the queue head (dm_we_o=1) at cmd_base_i, incrementing, popping on grant.
  - Queue never overflows; no word is dropped or duplicated under any grant pattern.
- ST_END: entered when len writes have been granted; pulse mem_rd_end_o and done_o together, then IDLE.
- Mutual exclusion: dm_req_o is never asserted outside LD_RUN/ST_RUN; at most one buffer handshake output is active per cycle apart from the wrtvalid strobes.
- Commands are not accepted while busy; cmd_valid_i is ignored outside IDLE.
- Reset mid-operation: immediate abort to reset values; no end pulse is issued.

Optional Feature:
- Macro: FDTD_MEMSEQ_CHKSUM_EN.
- When defined:
  - Adds output chksum_o [FDTD_DATA_WIDTH-1:0], the modulo-2^FDTD_DATA_WIDTH sum of every word transferred by the last completed command.
  - It is cleared on command accept and valid when done_o pulses.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- LD_HY, base=0x0100, len=4, gnt always 1, rdata=addr -> buffer_Hy_start_o pulse, 2 gap cycles, 4 contiguous wrtvalid_Hy_old_o with Hy_old_o=0x100..0x103, buffer_Hy_end_o next cycle, done_o.
- LD_EZ len=64 with gnt low every 3rd cycle -> exactly 64 strobes in address order, end pulse after the 64th, wait flag set.
- ST_EZ after LD_EZ, base=0x0200, len=3, Ez_n_i=0xA0+k -> mem_rd_Ez_en_o pulse, writes 0xA0,0xA1,0xA2 to 0x200..0x202, mem_rd_end_o with done_o.
- ST_HY with gnt held low 5 cycles mid-stream -> wrtvalid_sgl_o stalls, queue never exceeds 2 entries, all words written once.
- Illegal cases: len=0, len=65, op=6, ST_HY from reset -> err_o pulse for each; no dm_req_o or buffer pulses.
- Reset asserted in LD_RUN after 2 of 8 words -> all outputs at reset values, cmd_ready_o=1; a following LD_SRC len=2 completes normally.
